// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors, line levels.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial line of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );

endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity generator, shared by the transmitter and the receiver check.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity makes the total count of ones even; odd parity inverts it.
  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit,
// one bit per clk cycle; tx_out and busy are driven straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]      cnt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  par_bit;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  last_bit;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  assign cnt_nxt  = cnt + CNT_W'(1);
  assign last_bit = (cnt == CNT_W'(DATA_WIDTH - 1));

  // Each transition loads the line level of the state being entered,
  // so the registered outputs line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      cnt       <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q   <= LINE_IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
          if (bus.data_valid) begin
            data_q    <= bus.p_data;
            par_en_q  <= bus.par_en;
            par_typ_q <= bus.par_typ;
            state     <= START;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          state  <= DATA;
          cnt    <= '0;
          tx_q   <= data_q[0];
          busy_q <= 1'b1;
        end
        DATA: begin
          busy_q <= 1'b1;
          if (last_bit) begin
            cnt <= '0;
            if (par_en_q) begin
              state <= PARITY;
              tx_q  <= par_bit;
            end else begin
              state <= STOP;
              tx_q  <= STOP_BIT;
            end
          end else begin
            cnt  <= cnt_nxt;
            tx_q <= data_q[cnt_nxt];
          end
        end
        PARITY: begin
          state  <= STOP;
          tx_q   <= STOP_BIT;
          busy_q <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          tx_q   <= LINE_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tx_q   <= LINE_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level model, per-cycle compare,
// serial loopback receiver and hand-computed frame literals.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned W = DEF_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(W)) bus ();

  uart_tx #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Parity bit from a plain count of ones.
  function automatic logic model_par(logic [W-1:0] d, logic pt);
    int ones;
    ones = 0;
    for (int i = 0; i < int'(W); i++) ones += int'(d[i]);
    return ((ones % 2) == 1) ? ~pt : pt;
  endfunction

  typedef struct {
    logic [W-1:0] d;
    logic         pe;
    logic         pt;
  } frame_t;

  logic   q_bits[$];
  frame_t acc_q[$];
  logic   exp_tx   = 1'b1;
  logic   exp_busy = 1'b0;
  bit     started  = 1'b0;
  int     rx_pos   = -1;
  frame_t rx_f;
  logic [W-1:0] rx_d;
  logic   rx_p;

  // Frame-level model, per-cycle comparison and a loopback receiver.
  always @(posedge clk) begin
    logic r, v, pe, pt;
    logic [W-1:0] d;
    r  = rst;
    v  = bus.data_valid;
    d  = bus.p_data;
    pe = bus.par_en;
    pt = bus.par_typ;
    if (r) begin
      q_bits.delete();
      acc_q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      started  = 1'b1;
    end else if (!exp_busy) begin
      exp_tx = 1'b1;
      if (v) begin
        q_bits.push_back(1'b0);
        for (int i = 0; i < int'(W); i++) q_bits.push_back(d[i]);
        if (pe) q_bits.push_back(model_par(d, pt));
        q_bits.push_back(1'b1);
        acc_q.push_back('{d, pe, pt});
        exp_tx   = q_bits.pop_front();
        exp_busy = 1'b1;
      end
    end else if (q_bits.size() != 0) begin
      exp_tx = q_bits.pop_front();
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    #1;
    if (started) begin
      check("tx_out", 32'(bus.tx_out), 32'(exp_tx));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      if (r) begin
        rx_pos = -1;
      end else if (rx_pos < 0) begin
        if (bus.tx_out == 1'b0) begin
          if (acc_q.size() == 0) check("rx_unexpected_start", 32'd0, 32'd1);
          else begin
            rx_f   = acc_q.pop_front();
            rx_pos = 0;
          end
        end
      end else if (rx_pos < int'(W)) begin
        rx_d[rx_pos] = bus.tx_out;
        rx_pos++;
      end else if (rx_pos == int'(W) && rx_f.pe) begin
        rx_p = bus.tx_out;
        rx_pos++;
      end else begin
        check("rx_data", 32'(rx_d), 32'(rx_f.d));
        if (rx_f.pe) check("rx_par_error", 32'(rx_p != model_par(rx_d, rx_f.pt)), 32'd0);
        check("rx_stop_error", 32'(bus.tx_out != 1'b1), 32'd0);
        rx_pos = -1;
      end
    end
  end

  // One request, then capture the line while busy (first bit ends up MSB of cap).
  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt,
                      output logic [15:0] cap, output int n);
    int guard;
    @(negedge clk);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    cap   = '0;
    n     = 0;
    guard = 0;
    while (bus.busy && guard < 20) begin
      cap = {cap[14:0], bus.tx_out};
      n++;
      @(negedge clk);
      bus.p_data = ~bus.p_data;
      guard++;
    end
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (bus.busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check(name, 32'(bus.busy), 32'd0);
  endtask

  logic [15:0] cap;
  int          n;

  initial begin
    rst            = 1'b1;
    bus.data_valid = 1'b1;
    bus.p_data     = 8'h3C;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_tx", 32'(bus.tx_out), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
    end
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'({bus.tx_out, bus.busy}), 32'b10);

    send(8'hA5, 1'b1, PAR_EVEN, cap, n);
    check("a5_even_bits", 32'(cap), 32'h295);
    check("a5_even_len", 32'(n), 32'd11);
    send(8'hA5, 1'b1, PAR_ODD, cap, n);
    check("a5_odd_bits", 32'(cap), 32'h297);
    check("a5_odd_len", 32'(n), 32'd11);
    send(8'h00, 1'b1, PAR_ODD, cap, n);
    check("00_odd_bits", 32'(cap), 32'h003);
    send(8'h00, 1'b1, PAR_EVEN, cap, n);
    check("00_even_bits", 32'(cap), 32'h001);
    send(8'hFF, 1'b0, PAR_EVEN, cap, n);
    check("ff_nopar_bits", 32'(cap), 32'h1FF);
    check("ff_nopar_len", 32'(n), 32'd10);

    // Continuous requests with inputs changing every cycle.
    @(negedge clk);
    bus.data_valid = 1'b1;
    repeat (45) begin
      bus.p_data  = W'($urandom);
      bus.par_en  = 1'($urandom);
      bus.par_typ = 1'($urandom);
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    wait_idle("stream_timeout");
    @(negedge clk);

    // Abort during data bit 4 of 8'h5A, then a clean frame.
    bus.p_data     = 8'h5A;
    bus.par_en     = 1'b1;
    bus.par_typ    = PAR_EVEN;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("bit4_of_5a", 32'(bus.tx_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", 32'(bus.tx_out), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    send(8'hC3, 1'b1, PAR_ODD, cap, n);
    check("c3_odd_bits", 32'(cap), 32'h30F);
    check("c3_odd_len", 32'(n), 32'd11);

    // Loopback of 256 random bytes over every parity setting.
    for (int i = 0; i < 256; i++) begin
      send(W'($urandom), 1'(i), 1'(i >> 1), cap, n);
      check("loop_len", 32'(n), ((i % 2) == 1) ? 32'd11 : 32'd10);
    end
    repeat (2) @(negedge clk);
    check("rx_pending", 32'(acc_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the send-side counterpart of the team's UART receiver. Accepts a parallel byte with a valid strobe. Serializes it onto tx_out at one bit per clk cycle as start bit, data LSB-first, optional even/odd parity bit, then stop bit. The frame format matches the receiver, so tx_out can be looped back directly into the receiver's rx_in.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
p_data  input  DATA_WIDTH  parallel data; sampled only on the accept edge.
data_valid  input  1  request to send p_data; honoured only when busy=0.
par_en  input  1  1 = append parity bit; sampled on the accept edge.
par_typ  input  1  0 = even parity, 1 = odd parity; sampled on the accept edge.
tx_out  output  1  serial line; idles high.
busy  output  1  high while a frame is on the line (start bit through stop bit).

Behaviour:
- Reset (rst=1 at an edge): next cycle tx_out=1, busy=0, state=IDLE, bit counter=0, shift register cleared. Applies mid-frame too; the frame is aborted and no stop bit is sent.
- Outputs are registered. tx_out and busy come straight from flops with no combinational path from inputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, busy=0.
  - On an edge with data_valid=1, latch p_data, par_en and par_typ, then go to START. This edge is the accept edge.
  - Otherwise stay in IDLE.
- START: tx_out=0, busy=1, lasts one cycle, then DATA.
- DATA:
  - Drives the latched bits 0..DATA_WIDTH-1, LSB first, one per cycle.
  - Bit counter runs 0..DATA_WIDTH-1.
  - After the last bit, go to PARITY if the latched par_en=1, else go to STOP.
- PARITY: one cycle.
  - tx_out = XOR-reduce(data) for even parity.
  - tx_out = ~XOR-reduce(data) for odd parity.
  - This is identical to the receiver's check.
- STOP: tx_out=1, busy=1, one cycle, then IDLE.
- Latency: start bit appears on tx_out in the cycle immediately after the accept edge.
- Frame length: DATA_WIDTH+2 cycles without parity (10 at default), DATA_WIDTH+3 with parity (11 at default).
- Back-to-back frames:
  - data_valid is ignored while busy=1. There is no queue and no error flag; the request is dropped.
  - The earliest next accept is the edge ending the first IDLE cycle after STOP. This guarantees at least one idle-high cycle between frames.
- Input stability: changes to p_data, par_en or par_typ after the accept edge do not affect the frame in flight.
- Data holding: the latched data is held in a shift register, either shifted right each DATA cycle or indexed by the counter. Parity is computed from the latched value, not the live input.
- Illegal state encodings recover to IDLE with tx_out=1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding enum: IDLE, START, DATA, PARITY, STOP;
  - constants PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - line level constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1;
  - default DATA_WIDTH.
- The receiver is to import the same package.
- One sub-module: uart_parity_calc (inputs data[DATA_WIDTH-1:0] and par_typ, output par_bit), purely combinational. It is shared with the receiver for the parity check.

Test Plan:
- Reset: rst=1 for 2 cycles with data_valid=1 -> tx_out=1 and busy=0 throughout; no frame starts until rst=0.
- Even parity: p_data=8'hA5, par_en=1, par_typ=0, data_valid pulse in IDLE -> tx_out from next cycle = 0,1,0,1,0,0,1,0,1,0,1 (parity 0). busy=1 for exactly 11 cycles, then 0.
- Odd parity: p_data=8'hA5, par_en=1, par_typ=1 -> same sequence with parity bit 1. Also p_data=8'h00 odd -> parity 1, even -> parity 0.
- No parity: p_data=8'hFF, par_en=0 -> 0,1,1,1,1,1,1,1,1,1 (10 cycles). busy drops after the stop bit.
- Busy drop and input stability: hold data_valid=1 continuously with p_data changing each cycle -> only the value present on each accept edge is sent, at least one idle-high cycle separates frames, and no mid-frame corruption occurs.
- Reset mid-frame and loopback:
  - Assert rst during data bit 4 -> next cycle tx_out=1 and busy=0; a fresh frame then sends correctly.
  - Loop tx_out into the receiver for 256 random bytes across all par_en/par_typ combinations -> received p_data matches, with par_error=0 and stop_error=0.
